// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: bus widths, bus layouts, load
// encodings, response-tracking states and lane-extension helpers.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 125;
    localparam int MS_TO_WS_BUS_WD = 120;

    typedef enum logic [2:0] {
        LOAD_LW  = 3'd0,
        LOAD_LB  = 3'd1,
        LOAD_LBU = 3'd2,
        LOAD_LH  = 3'd3,
        LOAD_LHU = 3'd4
    } load_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } resp_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  mfc0_rd;
        logic        ex;
        logic [4:0]  exc_code;
        logic        bd;
        logic        eret;
        logic [2:0]  sel;
        logic        mtc0;
        logic        mfc0;
        load_op_e    load_op;
        logic        res_from_mem;
        logic        mem_req;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_bus_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  mfc0_rd;
        logic        ex;
        logic [4:0]  exc_code;
        logic        bd;
        logic        eret;
        logic [2:0]  sel;
        logic        mtc0;
        logic        mfc0;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_bus_t;

    function automatic logic [31:0] extend_byte(input logic [7:0] value, input logic signed_ext);
        return {{24{signed_ext & value[7]}}, value};
    endfunction

    function automatic logic [31:0] extend_half(input logic [15:0] value, input logic signed_ext);
        return {{16{signed_ext & value[15]}}, value};
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data alignment: picks the addressed byte/halfword lane out of the
// returned word and sign- or zero-extends it to 32 bits.
module mem_stage_load_ext
    import mem_stage_pkg::*;
(
    input  load_op_e    load_op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection from the low address bits
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (offset)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extension by load type; unknown encodings behave as a word load
    always_comb begin
        result = rdata;
        case (load_op)
            LOAD_LW:  result = rdata;
            LOAD_LB:  result = extend_byte(byte_s, 1'b1);
            LOAD_LBU: result = extend_byte(byte_s, 1'b0);
            LOAD_LH:  result = extend_half(half_s, 1'b1);
            LOAD_LHU: result = extend_half(half_s, 1'b0);
            default:  result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage between EXE and WB: holds one instruction, waits for the data
// SRAM response of loads/stores, and drops responses owed to flushed loads.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       flush,
    output logic [4:0]                 MEM_dest,
    output logic [31:0]                MEM_result,
    output logic                       ms_load_stall,
    output logic                       ms_ex_eret
);

    es_bus_t     in_s;
    es_bus_t     bus_r;
    ms_bus_t     out_s;
    logic        ms_valid_r;
    resp_state_e state_r;
    resp_state_e state_next_s;
    logic [31:0] rdata_buf_r;
    logic [31:0] rdata_sel_s;
    logic [31:0] load_data_s;
    logic [31:0] final_result_s;
    logic        data_have_s;
    logic        ready_go_s;
    logic        allowin_s;
    logic        accept_s;
    logic        new_req_s;

    assign in_s = es_to_ms_bus;

    // Handshake decode; data_ok feeds allowin combinationally so loads leave in the response cycle
    always_comb begin
        data_have_s = ((state_r == ST_WAIT) && data_sram_data_ok) || (state_r == ST_HOLD);
        ready_go_s  = !bus_r.mem_req || data_have_s;
        allowin_s   = (!ms_valid_r || (ready_go_s && ws_allowin)) && (state_r != ST_DISCARD);
        accept_s    = es_to_ms_valid && allowin_s;
        new_req_s   = accept_s && in_s.mem_req && !flush;
        if (state_r == ST_HOLD) begin
            rdata_sel_s = rdata_buf_r;
        end else begin
            rdata_sel_s = data_sram_rdata;
        end
    end

    // Response-tracking next state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (new_req_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (data_sram_data_ok) begin
                    // A response coinciding with flush is simply consumed
                    if (flush) begin
                        state_next_s = ST_IDLE;
                    end else if (ws_allowin) begin
                        state_next_s = new_req_s ? ST_WAIT : ST_IDLE;
                    end else begin
                        state_next_s = ST_HOLD;
                    end
                end else if (flush) begin
                    state_next_s = ST_DISCARD;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (ws_allowin) begin
                    state_next_s = new_req_s ? ST_WAIT : ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_DISCARD: begin
                if (data_sram_data_ok) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DISCARD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Response-tracking state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Instruction register and valid bit
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ms_valid_r <= 1'b0;
            bus_r      <= {ES_TO_MS_BUS_WD{1'b0}};
        end else if (allowin_s) begin
            ms_valid_r <= es_to_ms_valid;
            if (es_to_ms_valid) begin
                bus_r <= in_s;
            end
        end
    end

    // Captured response for a load that WB is not yet ready to take
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_buf_r <= 32'h0000_0000;
        end else if ((state_r == ST_WAIT) && data_sram_data_ok) begin
            rdata_buf_r <= data_sram_rdata;
        end
    end

    mem_stage_load_ext u_load_ext (
        .load_op (bus_r.load_op),
        .offset  (bus_r.addr[1:0]),
        .rdata   (rdata_sel_s),
        .result  (load_data_s)
    );

    // MEM->WB bus assembly
    always_comb begin
        if (bus_r.res_from_mem) begin
            final_result_s = load_data_s;
        end else begin
            final_result_s = bus_r.alu_result;
        end
        out_s              = {MS_TO_WS_BUS_WD{1'b0}};
        out_s.addr         = bus_r.addr;
        out_s.mfc0_rd      = bus_r.mfc0_rd;
        out_s.ex           = bus_r.ex;
        out_s.exc_code     = bus_r.exc_code;
        out_s.bd           = bus_r.bd;
        out_s.eret         = bus_r.eret;
        out_s.sel          = bus_r.sel;
        out_s.mtc0         = bus_r.mtc0;
        out_s.mfc0         = bus_r.mfc0;
        out_s.gr_we        = bus_r.gr_we;
        out_s.dest         = bus_r.dest;
        out_s.final_result = final_result_s;
        out_s.pc           = bus_r.pc;
    end

    assign ms_allowin     = allowin_s;
    assign ms_to_ws_valid = ms_valid_r && ready_go_s && !flush;
    assign ms_to_ws_bus   = out_s;
    assign MEM_dest       = bus_r.dest & {5{ms_valid_r}};
    assign MEM_result     = final_result_s;
    assign ms_load_stall  = ms_valid_r && bus_r.res_from_mem && !data_have_s;
    assign ms_ex_eret     = ms_valid_r && (bus_r.ex || bus_r.eret);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed corner cases plus randomized traffic, with a
// scoreboard fed at acceptance and drained by an output monitor.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [124:0] es_to_ms_bus;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [119:0] ms_to_ws_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         flush;
    logic [4:0]   MEM_dest;
    logic [31:0]  MEM_result;
    logic         ms_load_stall;
    logic         ms_ex_eret;

    int           tests = 0;
    int           fails = 0;
    logic [119:0] exp_q[$];
    logic [31:0]  rq_data[$];
    int           rq_delay[$];
    bit           rand_ws = 1'b0;
    logic [119:0] mon_e;
    logic         bad;
    logic         seen;
    int           stall_cnt;
    logic [31:0]  res_seen;
    int           kind;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .flush             (flush),
        .MEM_dest          (MEM_dest),
        .MEM_result        (MEM_result),
        .ms_load_stall     (ms_load_stall),
        .ms_ex_eret        (ms_ex_eret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Reference load semantics: lane picked by address, then extended
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  b = 8'(w >> (8 * off));
        logic [15:0] h = 16'(w >> (16 * off[1]));
        case (op)
            3'd1:    return {{24{b[7]}}, b};
            3'd2:    return {24'd0, b};
            3'd3:    return {{16{h[15]}}, h};
            3'd4:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [119:0] expect_of(input logic [124:0] b, input logic [31:0] rd);
        logic [31:0] fin = b[71] ? ref_load(b[74:72], b[94:93], rd) : b[63:32];
        return {b[124:75], b[69:64], fin, b[31:0]};
    endfunction

    // kind: 0 ALU, 1 load, 2 store
    function automatic logic [124:0] rand_bus(input int k);
        logic [124:0] b = 125'({$urandom(), $urandom(), $urandom(), $urandom()});
        b[74:72] = 3'($urandom_range(0, 4));
        b[71]    = (k == 1);
        b[70]    = (k != 0);
        return b;
    endfunction

    function automatic logic [124:0] mk(input int k, input logic [2:0] op, input logic [31:0] addr,
                                        input logic [31:0] alu, input logic [4:0] dest);
        logic [124:0] b = rand_bus(k);
        b[74:72]  = op;
        b[124:93] = addr;
        b[63:32]  = alu;
        b[68:64]  = dest;
        b[87]     = 1'b0;
        b[80]     = 1'b0;
        return b;
    endfunction

    // Called and returns just after a rising edge
    task automatic send(input logic [124:0] b, input logic [31:0] rd, input int dly);
        bit ok = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (ms_allowin) begin
                ok = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (ok) begin
            exp_q.push_back(expect_of(b, rd));
            if (b[70]) begin
                rq_data.push_back(rd);
                rq_delay.push_back(dly);
            end
        end else begin
            chk("send_timeout", 128'(ms_allowin), 128'(1'b1));
        end
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_flags"}, 128'({ms_allowin, ms_to_ws_valid, MEM_dest, ms_load_stall, ms_ex_eret, MEM_result}),
            128'({1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0}));
        chk({name, "_bus"}, 128'(ms_to_ws_bus), 128'(0));
    endtask

    // Data SRAM model: in-order responses, delay counted in cycles after entering MEM
    always @(posedge clk) begin
        #1;
        if (rq_delay.size() > 0 && rq_delay[0] == 0) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = rq_data[0];
        end else begin
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = $urandom;
            if (rq_delay.size() > 0) rq_delay[0] = rq_delay[0] - 1;
        end
    end

    always @(negedge clk) begin
        if (data_sram_data_ok && rq_data.size() > 0) begin
            void'(rq_data.pop_front());
            void'(rq_delay.pop_front());
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ws) ws_allowin = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: every WB handshake must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 128'(ms_to_ws_valid), 128'(1'b0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_bus", 128'(ms_to_ws_bus), 128'(mon_e));
                chk("out_side", 128'({MEM_dest, MEM_result, ms_ex_eret, ms_load_stall}),
                    128'({mon_e[68:64], mon_e[63:32], mon_e[82] | mon_e[75], 1'b0}));
            end
        end
    end

    initial begin
        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        flush             = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        step();

        // Stray response while idle must be ignored
        rq_data.push_back(32'hDEAD_BEEF);
        rq_delay.push_back(0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bad |= (!ms_allowin || ms_to_ws_valid || ms_load_stall);
            step();
        end
        chk("idle_dok", 128'(bad), 128'(1'b0));

        // Test 1: ALU instruction, one cycle in MEM
        send(mk(0, 3'd0, 32'h0, 32'h1234, 5'd5), 32'h0, 0);
        @(negedge clk);
        chk("t1_alu", 128'({ms_to_ws_valid, MEM_dest, MEM_result}), 128'({1'b1, 5'd5, 32'h1234}));
        step();

        // Test 2: lb at offset 3, response three cycles late
        send(mk(1, 3'd1, 32'h1000_0003, 32'h0, 5'd7), 32'h80FF_FFFF, 3);
        stall_cnt = 0;
        res_seen  = 32'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ms_load_stall) stall_cnt++;
            if (data_sram_data_ok) res_seen = MEM_result;
            step();
        end
        chk("t2_stall_cycles", 128'(stall_cnt), 128'(3));
        chk("t2_result", 128'(res_seen), 128'(32'hFFFF_FF80));

        // Test 3: lhu upper half, WB stalled two cycles -> held response
        ws_allowin = 1'b0;
        send(mk(1, 3'd4, 32'h2000_0002, 32'h0, 5'd9), 32'hBEEF_0000, 0);
        step();
        @(negedge clk);
        chk("t3_hold", 128'({ms_to_ws_valid, ms_load_stall, MEM_result}), 128'({1'b1, 1'b0, 32'h0000_BEEF}));
        step();
        ws_allowin = 1'b1;
        step();
        @(negedge clk);
        chk("t3_once", 128'(ms_to_ws_valid), 128'(1'b0));
        step();

        // Test 4: flush while waiting; late response is dropped
        send(mk(1, 3'd0, 32'h3000_0000, 32'h0, 5'd3), 32'h1111_2222, 5);
        step();
        flush = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("t4_flush_noout", 128'(ms_to_ws_valid), 128'(1'b0));
        step();
        flush = 1'b0;
        bad   = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (ms_allowin) bad = 1'b1;
            if (data_sram_data_ok) seen = 1'b1;
            step();
        end
        chk("t4_discard_blocks", 128'({bad, seen}), 128'({1'b0, 1'b1}));
        @(negedge clk);
        chk("t4_reopen", 128'(ms_allowin), 128'(1'b1));
        step();
        send(mk(1, 3'd2, 32'h3000_0001, 32'h0, 5'd4), 32'h0000_A500, 1);
        repeat (4) step();

        // Test 5: response and flush together -> no discard
        send(mk(1, 3'd0, 32'h4000_0000, 32'h0, 5'd6), 32'h5566_7788, 2);
        step();
        step();
        flush = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("t5_dok_flush", 128'({data_sram_data_ok, ms_to_ws_valid}), 128'({1'b1, 1'b0}));
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("t5_allowin_next", 128'(ms_allowin), 128'(1'b1));
        step();
        send(mk(0, 3'd0, 32'h0, 32'hCAFE_0001, 5'd8), 32'h0, 0);
        repeat (3) step();

        // Test 6: reset while waiting for a response
        send(mk(1, 3'd0, 32'h5000_0000, 32'h0, 5'd2), 32'h1234_5678, 10);
        step();
        reset = 1'b1;
        rq_data.delete();
        rq_delay.delete();
        exp_q.delete();
        step();
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_reset");
        step();

        // Randomized traffic with random WB back-pressure and response latency
        rand_ws = 1'b1;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 2);
            repeat ($urandom_range(0, 2)) step();
            send(rand_bus(kind), $urandom, $urandom_range(0, 4));
        end
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) step();
        chk("drain", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between EXE and WB in the five-stage MIPS core on the AXI bridge. It accepts one instruction per handshake from EXE. For loads it waits for the data-SRAM response, extracting and extending the addressed byte or halfword. It forwards the 120-bit MEM→WB bus to `wb_stage`, honouring WB's `flush` and discarding any response still outstanding for a flushed load.

## Interface
- `ES_TO_MS_BUS_WD`, 125: EXE→MEM bus width; shared constant.
- `MS_TO_WS_BUS_WD`, 120: MEM→WB bus width; shared constant.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `ms_allowin`  out  1  MEM can accept from EXE this cycle
- `es_to_ms_valid`  in  1  EXE holds a valid instruction
- `es_to_ms_bus`  in  125  fields, MSB→LSB:
  - addr[124:93], mfc0_rd[92:88], ex[87], ExcCode[86:82], bd[81], eret[80], sel[79:77], mtc0[76], mfc0[75]
  - load_op[74:72]: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu
  - res_from_mem[71], mem_req[70]: EXE request accepted via addr_ok
  - gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]
- `ws_allowin`  in  1  WB can accept
- `ms_to_ws_valid`  out  1  valid to WB
- `ms_to_ws_bus`  out  120  {addr, mfc0_rd, ex, ExcCode, bd, eret, sel, mtc0, mfc0, gr_we, dest, final_result, pc}
- `data_sram_data_ok`  in  1  one read/write response, in request order
- `data_sram_rdata`  in  32  read data, valid with data_ok
- `flush`  in  1  WB exception/eret flush
- `MEM_dest`  out  5  dest gated by ms_valid; feeds ID forwarding
- `MEM_result`  out  32  final_result; feeds ID forwarding
- `ms_load_stall`  out  1  ms_valid & res_from_mem & !data_have; ID must stall a dependent instruction
- `ms_ex_eret`  out  1  ms_valid & (ex | eret); EXE suppresses stores

## Operation
- The bus register latches `es_to_ms_bus` when `es_to_ms_valid && ms_allowin`. On reset or `flush`, the bus register is zeroed and `ms_valid` is cleared.
- Response FSM:
  - IDLE: no outstanding response.
  - WAIT: `ms_valid & mem_req`, response pending.
  - HOLD: response captured in `rdata_buf`; `data_have=1`.
  - DISCARD: flushed while a response is outstanding.
- Transitions:
  - IDLE→WAIT: an instruction with mem_req is accepted.
  - WAIT→IDLE: data_ok and the instruction leaves the same cycle.
  - WAIT→HOLD: data_ok but `!ws_allowin`.
  - HOLD→IDLE: the instruction leaves.
  - WAIT→DISCARD: `flush` without data_ok.
  - DISCARD→IDLE: data_ok; the data is dropped.
  - `flush` in HOLD goes to IDLE.
- `data_have` = data_ok (in WAIT) | HOLD.
- `ms_ready_go` = !mem_req | data_have.
- `ms_allowin` = (!ms_valid | (ms_ready_go & ws_allowin)) & state≠DISCARD.
- `ms_to_ws_valid` = ms_valid & ms_ready_go & !flush.
- Load data is taken from `rdata_buf` in HOLD, otherwise from `data_sram_rdata`. Byte offset is addr[1:0]:
  - lb/lbu: byte at offset, sign-/zero-extended.
  - lh/lhu: halfword at addr[1], sign-/zero-extended.
  - lw: the word.
- `final_result` = res_from_mem ? load_data : alu_result.
- Stores (mem_req=1, res_from_mem=0) still consume their data_ok.

## Timing
- Reset values: ms_valid 0, state IDLE, bus register 0, ms_to_ws_valid 0, MEM_dest 0, ms_load_stall 0, ms_ex_eret 0, ms_allowin 1.
- Latency for a non-memory instruction: 1 cycle in MEM.
- Loads leave in the data_ok cycle. The data_ok→ms_allowin path is combinational.
- A data_ok arriving in IDLE is ignored.
- data_ok and flush in the same cycle while in WAIT: the response is consumed and the next state is IDLE, not DISCARD.
- Reset mid-WAIT returns to IDLE. The bridge is reset in the same cycle.

## Structure
- `global_defines.vh` holds both bus widths, the load_op encodings, and the FSM state encodings.
- A sub-module `load_ext` (combinational: load_op, addr[1:0], rdata → 32-bit result) is natural.

## Test plan
- Test 1: `addu` with alu_result 0x1234 and dest 5 → `ms_to_ws_valid` 1 cycle after acceptance; final_result 0x1234; MEM_dest 5.
- Test 2: `lb`, addr 0x...3, data_ok after 3 cycles with rdata 0x80FF_FF_FF:
  - result 0xFFFFFF80.
  - `ms_load_stall` high for 3 cycles.
- Test 3: `lhu`, addr[1]=1, rdata 0xBEEF0000, data_ok while ws_allowin=0 for 2 cycles → HOLD; result 0x0000BEEF delivered once ws_allowin=1.
- Test 4: flush while in WAIT:
  - ms_allowin=0 until a later data_ok.
  - That data is never forwarded.
  - The next load receives its own data.
- Test 5: data_ok and flush in the same cycle → IDLE; ms_allowin=1 the next cycle; no discard.
- Test 6: reset asserted mid-WAIT → all outputs at reset values the next cycle.
